// File: rtl/pc_sequencer.sv
// Program counter owner for the RV32IM core: selects the next PC, sequences
// instruction fetch over a req/ready handshake and raises misaligned-target traps.

module pc_sequencer #(
   parameter int                    PC_WIDTH     = 32,
   parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = 32'h0000_0000,
   parameter logic [PC_WIDTH-1:0]   TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            PCSel,
   input  logic                  BranchTaken,
   input  logic [PC_WIDTH-1:0]   BranchTarget,
   input  logic [PC_WIDTH-1:0]   JumpTarget,
   input  logic                  Stall,
   input  logic                  imem_ready,
   input  logic                  TrapAck,
   output logic                  imem_req,
   output logic                  InstrValid,
   output logic                  Retire,
   output logic [PC_WIDTH-1:0]   PC,
   output logic [PC_WIDTH-1:0]   PC_Plus_4,
   output logic                  MisalignTrap,
   output logic [PC_WIDTH-1:0]   TrapPC,
   output logic [PC_WIDTH-1:0]   TrapTarget
);

   // state   | meaning
   // S_IDLE  | one cycle after reset release, all outputs low
   // S_FETCH | imem_req high, waiting for imem_ready; PC held
   // S_EXEC  | instruction executing; retires or traps when Stall is low
   // S_TRAP  | misaligned-target trap pending until TrapAck
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_TRAP  = 2'd3
   } state_t;

   state_t              state;
   logic [PC_WIDTH-1:0] next_pc;
   logic                misaligned;

   assign PC_Plus_4 = PC + PC_WIDTH'(4);

   always_comb begin
      next_pc = PC_Plus_4;
      case (PCSel)
         2'b01:   if (BranchTaken) next_pc = BranchTarget;
         2'b10:   next_pc = JumpTarget;
         default: next_pc = PC_Plus_4;
      endcase
   end

   assign misaligned = (next_pc[1:0] != 2'b00);

   // InstrValid is high only in EXEC, so the commit decision needs no state decode.
   assign Retire = InstrValid & ~Stall & ~misaligned;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         PC           <= RESET_VECTOR;
         imem_req     <= 1'b0;
         InstrValid   <= 1'b0;
         MisalignTrap <= 1'b0;
         TrapPC       <= '0;
         TrapTarget   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               state    <= S_FETCH;
               imem_req <= 1'b1;
            end
            S_FETCH: begin
               if (imem_ready) begin
                  state      <= S_EXEC;
                  imem_req   <= 1'b0;
                  InstrValid <= 1'b1;
               end
            end
            S_EXEC: begin
               if (!Stall) begin
                  InstrValid <= 1'b0;
                  if (!misaligned) begin
                     PC       <= next_pc;
                     state    <= S_FETCH;
                     imem_req <= 1'b1;
                  end else begin
                     TrapPC       <= PC;
                     TrapTarget   <= next_pc;
                     state        <= S_TRAP;
                     MisalignTrap <= 1'b1;
                  end
               end
            end
            S_TRAP: begin
               if (TrapAck) begin
                  PC           <= TRAP_VECTOR;
                  MisalignTrap <= 1'b0;
                  state        <= S_FETCH;
                  imem_req     <= 1'b1;
               end
            end
            default: begin
               state        <= S_IDLE;
               imem_req     <= 1'b0;
               InstrValid   <= 1'b0;
               MisalignTrap <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// instruction streams checked against a per-instruction reference model.

module tb_pc_sequencer;

   localparam logic [31:0] RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

   logic        clk;
   logic        rst_n;
   logic [1:0]  PCSel;
   logic        BranchTaken;
   logic [31:0] BranchTarget;
   logic [31:0] JumpTarget;
   logic        Stall;
   logic        imem_ready;
   logic        TrapAck;
   logic        imem_req;
   logic        InstrValid;
   logic        Retire;
   logic [31:0] PC;
   logic [31:0] PC_Plus_4;
   logic        MisalignTrap;
   logic [31:0] TrapPC;
   logic [31:0] TrapTarget;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_pc;
   logic [31:0] exp_trap_pc;
   logic [31:0] exp_trap_tgt;

   pc_sequencer #(
      .PC_WIDTH     (32),
      .RESET_VECTOR (RESET_VEC),
      .TRAP_VECTOR  (TRAP_VEC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .PCSel        (PCSel),
      .BranchTaken  (BranchTaken),
      .BranchTarget (BranchTarget),
      .JumpTarget   (JumpTarget),
      .Stall        (Stall),
      .imem_ready   (imem_ready),
      .TrapAck      (TrapAck),
      .imem_req     (imem_req),
      .InstrValid   (InstrValid),
      .Retire       (Retire),
      .PC           (PC),
      .PC_Plus_4    (PC_Plus_4),
      .MisalignTrap (MisalignTrap),
      .TrapPC       (TrapPC),
      .TrapTarget   (TrapTarget)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference rule for the address following an instruction.
   function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [1:0] sel,
                                            input logic taken, input logic [31:0] bt,
                                            input logic [31:0] jt);
      if (sel == 2'b10) return jt;
      if (sel == 2'b01 && taken) return bt;
      return pc + 32'd4;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_side_inputs();
      PCSel        = 2'($urandom_range(0, 3));
      BranchTaken  = 1'($urandom_range(0, 1));
      BranchTarget = $urandom;
      JumpTarget   = $urandom;
   endtask

   task automatic check_fetch(input string tag);
      chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
      chk({tag, "_valid"}, {31'd0, InstrValid}, 32'd0);
      chk({tag, "_retire"}, {31'd0, Retire}, 32'd0);
      chk({tag, "_pc"}, PC, exp_pc);
   endtask

   // Reset held across a clock edge, released, IDLE cycle checked, then FETCH.
   task automatic do_reset();
      rst_n = 1'b0;
      Stall = 1'b0; imem_ready = 1'b0; TrapAck = 1'b0;
      PCSel = 2'b00; BranchTaken = 1'b0; BranchTarget = '0; JumpTarget = '0;
      #1;
      chk("rst_pc", PC, RESET_VEC);
      chk("rst_trap", {31'd0, MisalignTrap}, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, InstrValid}, 32'd0);
      chk("rst_trappc", TrapPC, 32'd0);
      chk("rst_traptgt", TrapTarget, 32'd0);
      exp_pc = RESET_VEC;
      exp_trap_pc = '0;
      exp_trap_tgt = '0;
      tick();
      rst_n = 1'b1;
      #1;
      chk("idle_req", {31'd0, imem_req}, 32'd0);
      chk("idle_retire", {31'd0, Retire}, 32'd0);
      tick();
      check_fetch("post_rst");
   endtask

   // One full instruction starting at the first FETCH cycle.
   task automatic run_instr(input int waits, input int stalls, input logic [1:0] sel,
                            input logic taken, input logic [31:0] bt, input logic [31:0] jt,
                            input int ack_delay);
      logic [31:0] nxt;
      for (int i = 0; i < waits; i++) begin
         imem_ready = 1'b0;
         Stall = 1'($urandom_range(0, 1));
         TrapAck = 1'($urandom_range(0, 1));
         randomize_side_inputs();
         #1;
         check_fetch("fetch_wait");
         tick();
      end
      imem_ready = 1'b1;
      Stall = 1'($urandom_range(0, 1));
      TrapAck = 1'($urandom_range(0, 1));
      #1;
      check_fetch("fetch_hit");
      tick();
      for (int i = 0; i < stalls; i++) begin
         Stall = 1'b1;
         imem_ready = 1'($urandom_range(0, 1));
         TrapAck = 1'($urandom_range(0, 1));
         PCSel = 2'b10;
         JumpTarget = $urandom | 32'h1;
         #1;
         chk("stall_valid", {31'd0, InstrValid}, 32'd1);
         chk("stall_retire", {31'd0, Retire}, 32'd0);
         chk("stall_req", {31'd0, imem_req}, 32'd0);
         chk("stall_trap", {31'd0, MisalignTrap}, 32'd0);
         chk("stall_pc", PC, exp_pc);
         tick();
      end
      Stall = 1'b0;
      imem_ready = 1'($urandom_range(0, 1));
      TrapAck = 1'($urandom_range(0, 1));
      PCSel = sel; BranchTaken = taken; BranchTarget = bt; JumpTarget = jt;
      nxt = ref_next(exp_pc, sel, taken, bt, jt);
      #1;
      chk("exec_valid", {31'd0, InstrValid}, 32'd1);
      chk("exec_pc", PC, exp_pc);
      chk("exec_pc4", PC_Plus_4, exp_pc + 32'd4);
      chk("exec_retire", {31'd0, Retire}, {31'd0, (nxt[1:0] == 2'b00)});
      tick();
      if (nxt[1:0] == 2'b00) begin
         exp_pc = nxt;
         return;
      end
      exp_trap_pc = exp_pc;
      exp_trap_tgt = nxt;
      for (int i = 0; i <= ack_delay; i++) begin
         TrapAck = (i == ack_delay);
         Stall = 1'($urandom_range(0, 1));
         imem_ready = 1'($urandom_range(0, 1));
         randomize_side_inputs();
         #1;
         chk("trap_flag", {31'd0, MisalignTrap}, 32'd1);
         chk("trap_retire", {31'd0, Retire}, 32'd0);
         chk("trap_req", {31'd0, imem_req}, 32'd0);
         chk("trap_pc", TrapPC, exp_trap_pc);
         chk("trap_tgt", TrapTarget, exp_trap_tgt);
         chk("trap_hold_pc", PC, exp_pc);
         tick();
      end
      TrapAck = 1'b0;
      exp_pc = TRAP_VEC;
      #1;
      chk("ack_flag", {31'd0, MisalignTrap}, 32'd0);
      chk("ack_trappc", TrapPC, exp_trap_pc);
      check_fetch("ack_fetch");
   endtask

   initial begin
      logic [31:0] t;
      do_reset();

      // Sequential fetch with a zero-wait memory.
      for (int i = 0; i < 4; i++) run_instr(0, 0, 2'b00, 1'b0, 32'h0, 32'h0, 0);
      chk("seq_pc", exp_pc, 32'h10);
      chk("seq_dut_pc", PC, 32'h10);

      // Branch taken, not taken, then jump.
      run_instr(0, 0, 2'b01, 1'b1, 32'h40, 32'h0, 0);
      chk("br_taken", PC, 32'h40);
      run_instr(0, 0, 2'b01, 1'b0, 32'h80, 32'h0, 0);
      chk("br_not", PC, 32'h44);
      run_instr(0, 0, 2'b10, 1'b0, 32'h0, 32'h200, 0);
      chk("jump", PC, 32'h200);
      run_instr(0, 0, 2'b11, 1'b1, 32'h8, 32'h8, 0);
      chk("sel11", PC, 32'h204);

      // Memory wait and stall.
      run_instr(3, 4, 2'b00, 1'b0, 32'h0, 32'h0, 0);
      chk("wait_stall", PC, 32'h208);

      // Misaligned jump from 0x20.
      run_instr(0, 0, 2'b10, 1'b0, 32'h0, 32'h20, 0);
      run_instr(0, 0, 2'b10, 1'b0, 32'h0, 32'h102, 2);
      chk("mis_vec", PC, TRAP_VEC);
      chk("mis_trappc", TrapPC, 32'h20);
      chk("mis_traptgt", TrapTarget, 32'h102);

      // Stall with misaligned targets, then taken misaligned branch.
      run_instr(1, 2, 2'b01, 1'b1, 32'h333, 32'h0, 1);

      // Wrap at the top of the address space.
      run_instr(0, 0, 2'b10, 1'b0, 32'h0, 32'hFFFF_FFFC, 0);
      chk("wrap_pc4", PC_Plus_4, 32'h0);
      run_instr(0, 0, 2'b00, 1'b0, 32'h0, 32'h0, 0);
      chk("wrap_pc", PC, 32'h0);
      chk("wrap_notrap", {31'd0, MisalignTrap}, 32'd0);

      // Randomized instruction stream.
      for (int n = 0; n < 300; n++) begin
         t = $urandom;
         if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
         run_instr($urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), t, {t[31:2], t[1:0] ^ 2'($urandom_range(0, 1))},
                   $urandom_range(0, 3));
      end

      // Async reset mid-stall.
      run_instr(0, 0, 2'b10, 1'b0, 32'h0, 32'h300, 0);
      imem_ready = 1'b1;
      tick();
      Stall = 1'b1;
      tick();
      #3;
      do_reset();
      run_instr(0, 0, 2'b00, 1'b0, 32'h0, 32'h0, 0);
      chk("restart1", PC, 32'h4);

      // Async reset while in TRAP.
      imem_ready = 1'b1; Stall = 1'b0;
      tick();
      PCSel = 2'b10; JumpTarget = 32'h6;
      tick();
      #1;
      chk("pre_rst_trap", {31'd0, MisalignTrap}, 32'd1);
      #2;
      do_reset();
      run_instr(0, 0, 2'b00, 1'b0, 32'h0, 32'h0, 0);
      chk("restart2", PC, 32'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
